// File: rtl/m_cycle_pkg.sv
// M-cycle type shared by the sequencer and the controller decoder, plus the
// per-opcode sequence descriptor used inside the sequencer.
package m_cycle_pkg;

  typedef enum logic [4:0] {
    M_FETCH, M_IDLE, M_ROM_READ, M_REG_WRITE, M_REG_COPY, M_MEM_READ,
    M_MEM_WRITE, M_ALU_CALC, M_PC_WRITE, M_PUSH_PCH, M_PUSH_PCL, M_POP1,
    M_POP2, M_SP_INC, M_RST_ADDR_COPY, M_PUSH1, M_PUSH2, M_REG16_WRITE,
    M_STORE_SPL, M_STORE_SPH, M_DAA, M_BITALU_CALC, M_ADDER16_CALC, M_SHIFT
  } m_cycle_type;

  // len execute steps; when has_cond, a false cc ends the sequence at the
  // tick that closes step cond_step.
  typedef struct packed {
    logic [2:0]             len;
    logic                   has_cond;
    logic [2:0]             cond_step;
    logic                   halt;
    logic                   lock;
    m_cycle_type [4:0]      cyc;
  } seq_t;

endpackage

// File: rtl/m_cycle_sequencer.sv
// Per-instruction M-cycle sequencer: fetch, execute, HALT, interrupt dispatch, lock.
// Optional HALT_BUG_EN adds pc_inc_inhibit for the DMG halt bug.
module m_cycle_sequencer
  import m_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic        m_tick,
  input  logic [7:0]  op,
  input  logic [7:0]  op_prefix,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        ime,
  input  logic        irq_pending,
  output m_cycle_type m_cycle,
  output logic        interrupt,
  output logic        op_load,
  output logic        prefix_load,
  output logic        int_ack,
  output logic        halted
`ifdef HALT_BUG_EN
  ,
  output logic        pc_inc_inhibit
`endif
);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_HALT, S_INT, S_LOCK} state_e;

  function automatic seq_t mk(input logic [2:0] n,
                              input m_cycle_type c0 = M_IDLE,
                              input m_cycle_type c1 = M_IDLE,
                              input m_cycle_type c2 = M_IDLE,
                              input m_cycle_type c3 = M_IDLE,
                              input m_cycle_type c4 = M_IDLE);
    seq_t m;
    m        = '0;
    m.len    = n;
    m.cyc[0] = c0;
    m.cyc[1] = c1;
    m.cyc[2] = c2;
    m.cyc[3] = c3;
    m.cyc[4] = c4;
    return m;
  endfunction

  // op and op_prefix are taken as valid on the tick that latches them.
  function automatic seq_t seq_of(input logic [7:0] o, input logic [7:0] p);
    seq_t        s;
    m_cycle_type k;
    s = mk(3'd0);
    k = (p[7:6] == 2'b00) ? M_SHIFT : M_BITALU_CALC;
    casez (o)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: s.lock = 1'b1;
      8'h76:        s.halt = 1'b1;
      8'h00, 8'hF3, 8'hFB: s.len = 3'd0;
      8'h08:        s = mk(3'd4, M_ROM_READ, M_ROM_READ, M_STORE_SPL, M_STORE_SPH);
      8'h10:        s = mk(3'd1, M_ROM_READ);
      8'h18:        s = mk(3'd2, M_ROM_READ, M_PC_WRITE);
      8'h27:        s = mk(3'd1, M_DAA);
      8'h2F:        s = mk(3'd1, M_ALU_CALC);
      8'h37, 8'h3F: s = mk(3'd1, M_BITALU_CALC);
      8'h34, 8'h35: s = mk(3'd2, M_MEM_READ, M_MEM_WRITE);
      8'h36:        s = mk(3'd2, M_ROM_READ, M_MEM_WRITE);
      8'b001??000: begin
        s = mk(3'd2, M_ROM_READ, M_PC_WRITE);
        s.has_cond = 1'b1;
      end
      8'b00??0001: s = mk(3'd2, M_ROM_READ, M_ROM_READ);
      8'b00??0010: s = mk(3'd1, M_MEM_WRITE);
      8'b00??1010: s = mk(3'd1, M_MEM_READ);
      8'b00???011, 8'b00??1001: s = mk(3'd1, M_ADDER16_CALC);
      8'b00???10?: s = mk(3'd1, M_ALU_CALC);
      8'b00???110: s = mk(3'd2, M_ROM_READ, M_REG_WRITE);
      8'b000??111: s = mk(3'd1, M_SHIFT);
      8'b01??????: begin
        if (o[5:3] == o[2:0])      s = mk(3'd0);
        else if (o[2:0] == 3'd6)   s = mk(3'd1, M_MEM_READ);
        else if (o[5:3] == 3'd6)   s = mk(3'd1, M_MEM_WRITE);
        else                       s = mk(3'd1, M_REG_COPY);
      end
      8'b10??????: s = (o[2:0] == 3'd6) ? mk(3'd2, M_MEM_READ, M_ALU_CALC)
                                        : mk(3'd1, M_ALU_CALC);
      8'b110??000: begin
        s = mk(3'd4, M_IDLE, M_POP1, M_POP2, M_SP_INC);
        s.has_cond = 1'b1;
      end
      8'b110??010: begin
        s = mk(3'd3, M_ROM_READ, M_ROM_READ, M_PC_WRITE);
        s.has_cond  = 1'b1;
        s.cond_step = 3'd1;
      end
      8'b110??100: begin
        s = mk(3'd5, M_ROM_READ, M_ROM_READ, M_PUSH_PCH, M_PUSH_PCL, M_PC_WRITE);
        s.has_cond  = 1'b1;
        s.cond_step = 3'd1;
      end
      8'hC3:        s = mk(3'd3, M_ROM_READ, M_ROM_READ, M_PC_WRITE);
      8'hCD:        s = mk(3'd5, M_ROM_READ, M_ROM_READ, M_PUSH_PCH, M_PUSH_PCL, M_PC_WRITE);
      8'hC9, 8'hD9: s = mk(3'd3, M_POP1, M_POP2, M_SP_INC);
      8'hCB:        s = (p[2:0] == 3'd6) ? mk(3'd3, M_ROM_READ, M_MEM_READ, k)
                                         : mk(3'd2, M_ROM_READ, k);
      8'hE0:        s = mk(3'd2, M_ROM_READ, M_MEM_WRITE);
      8'hF0:        s = mk(3'd2, M_ROM_READ, M_MEM_READ);
      8'hE2:        s = mk(3'd1, M_MEM_WRITE);
      8'hF2:        s = mk(3'd1, M_MEM_READ);
      8'hE8, 8'hF8: s = mk(3'd2, M_ROM_READ, M_ADDER16_CALC);
      8'hE9:        s = mk(3'd1, M_PC_WRITE);
      8'hEA:        s = mk(3'd3, M_ROM_READ, M_ROM_READ, M_MEM_WRITE);
      8'hFA:        s = mk(3'd3, M_ROM_READ, M_ROM_READ, M_MEM_READ);
      8'hF9:        s = mk(3'd1, M_ADDER16_CALC);
      8'b11??0001:  s = mk(3'd3, M_POP1, M_POP2, M_REG16_WRITE);
      8'b11??0101:  s = mk(3'd3, M_PUSH1, M_PUSH2, M_SP_INC);
      8'b11???110:  s = mk(3'd2, M_ROM_READ, M_ALU_CALC);
      8'b11???111:  s = mk(3'd4, M_RST_ADDR_COPY, M_PUSH_PCH, M_PUSH_PCL, M_PC_WRITE);
      default:      s = mk(3'd0);
    endcase
    return s;
  endfunction

  function automatic m_cycle_type int_cyc(input logic [2:0] st);
    case (st)
      3'd2:    return M_PUSH_PCH;
      3'd3:    return M_PUSH_PCL;
      3'd4:    return M_PC_WRITE;
      default: return M_IDLE;
    endcase
  endfunction

  state_e      state_q;
  logic [2:0]  step_q;
  m_cycle_type m_cycle_q;
  logic        interrupt_q;
  logic        halted_q;
  seq_t        sq;
  logic        cc_ok;
  logic        last_step;
  logic        take_int;
  logic [2:0]  step_nx;

  always_comb begin
    sq = seq_of(op, op_prefix);
    case (op[4:3])
      2'b00:   cc_ok = ~flag_z;
      2'b01:   cc_ok = flag_z;
      2'b10:   cc_ok = ~flag_c;
      default: cc_ok = flag_c;
    endcase
    step_nx   = step_q + 3'd1;
    last_step = (step_nx == sq.len) ||
                (sq.has_cond && (step_q == sq.cond_step) && !cc_ok);
    take_int  = ime && irq_pending;
  end

`ifdef HALT_BUG_EN
  logic inhibit_q;
  assign pc_inc_inhibit = inhibit_q;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_FETCH;
      step_q      <= 3'd0;
      m_cycle_q   <= M_FETCH;
      interrupt_q <= 1'b0;
      halted_q    <= 1'b0;
`ifdef HALT_BUG_EN
      inhibit_q   <= 1'b0;
`endif
    end else if (m_tick) begin
`ifdef HALT_BUG_EN
      inhibit_q <= 1'b0;
`endif
      step_q <= 3'd0;
      case (state_q)
        S_FETCH: begin
          if (sq.lock) begin
            state_q   <= S_LOCK;
            m_cycle_q <= M_IDLE;
          end else if (sq.halt) begin
            state_q   <= S_HALT;
            m_cycle_q <= M_IDLE;
            halted_q  <= 1'b1;
          end else if (sq.len != 3'd0) begin
            state_q   <= S_EXEC;
            m_cycle_q <= sq.cyc[0];
          end else if (take_int) begin
            state_q     <= S_INT;
            m_cycle_q   <= M_IDLE;
            interrupt_q <= 1'b1;
          end else begin
            m_cycle_q <= M_FETCH;
          end
        end
        S_EXEC: begin
          if (!last_step) begin
            step_q    <= step_nx;
            m_cycle_q <= sq.cyc[step_nx];
          end else if (take_int) begin
            state_q     <= S_INT;
            m_cycle_q   <= M_IDLE;
            interrupt_q <= 1'b1;
          end else begin
            state_q   <= S_FETCH;
            m_cycle_q <= M_FETCH;
          end
        end
        S_HALT: begin
          if (irq_pending) begin
            halted_q <= 1'b0;
            if (ime) begin
              state_q     <= S_INT;
              m_cycle_q   <= M_IDLE;
              interrupt_q <= 1'b1;
            end else begin
              state_q   <= S_FETCH;
              m_cycle_q <= M_FETCH;
`ifdef HALT_BUG_EN
              inhibit_q <= 1'b1;
`endif
            end
          end
        end
        S_INT: begin
          // Dispatch runs to completion even if irq_pending drops.
          if (step_q == 3'd4) begin
            state_q     <= S_FETCH;
            m_cycle_q   <= M_FETCH;
            interrupt_q <= 1'b0;
          end else begin
            step_q    <= step_nx;
            m_cycle_q <= int_cyc(step_nx);
          end
        end
        default: begin
          state_q   <= S_LOCK;
          m_cycle_q <= M_IDLE;
        end
      endcase
    end
  end

  assign m_cycle     = m_cycle_q;
  assign interrupt   = interrupt_q;
  assign halted      = halted_q;
  // Strobes are forced low while reset is held so no pending latch fires.
  assign op_load     = n_reset && m_tick && (state_q == S_FETCH);
  assign prefix_load = n_reset && m_tick && (state_q == S_EXEC) &&
                       (step_q == 3'd0) && (op == 8'hCB);
  assign int_ack     = n_reset && m_tick && (state_q == S_INT) && (step_q == 3'd4);

endmodule

// File: tb/tb_m_cycle_sequencer.sv
// Directed bench for m_cycle_sequencer with an expected-M-cycle scoreboard.
module tb_m_cycle_sequencer;
  import m_cycle_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        m_tick = 1'b0;
  logic [7:0]  op = 8'h00;
  logic [7:0]  op_prefix = 8'h00;
  logic        flag_z = 1'b0;
  logic        flag_c = 1'b0;
  logic        ime = 1'b0;
  logic        irq_pending = 1'b0;
  m_cycle_type m_cycle;
  logic        interrupt, op_load, prefix_load, int_ack, halted;
`ifdef HALT_BUG_EN
  logic        pc_inc_inhibit;
`endif

  typedef struct {
    m_cycle_type cyc;
    logic        intr;
    logic        hlt;
  } exp_t;

  exp_t  exp_q[$];
  int    cmp_cnt = 0;
  int    err_cnt = 0;
  int    n_opload = 0;
  int    n_pfx = 0;
  int    n_ack = 0;
  string phase = "init";

  always #5 clk = ~clk;

  m_cycle_sequencer dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .m_tick      (m_tick),
    .op          (op),
    .op_prefix   (op_prefix),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .ime         (ime),
    .irq_pending (irq_pending),
    .m_cycle     (m_cycle),
    .interrupt   (interrupt),
    .op_load     (op_load),
    .prefix_load (prefix_load),
    .int_ack     (int_ack),
    .halted      (halted)
`ifdef HALT_BUG_EN
    ,
    .pc_inc_inhibit (pc_inc_inhibit)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic push(input m_cycle_type c, input logic i = 1'b0, input logic h = 1'b0);
    exp_q.push_back('{c, i, h});
  endtask

  task automatic clr_cnt();
    n_opload = 0;
    n_pfx    = 0;
    n_ack    = 0;
  endtask

  // One-clk tick, then compare against the scoreboard; one quiet clk follows
  // to confirm the outputs hold between ticks.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    m_tick = 1'b1;
    #1;
    n_opload += int'(op_load);
    n_pfx    += int'(prefix_load);
    n_ack    += int'(int_ack);
    @(negedge clk);
    m_tick = 1'b0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("m_cycle",   32'(m_cycle),   32'(e.cyc));
      chk("interrupt", 32'(interrupt), 32'(e.intr));
      chk("halted",    32'(halted),    32'(e.hlt));
      @(negedge clk);
      chk("m_cycle_hold", 32'(m_cycle), 32'(e.cyc));
    end
  endtask

  task automatic drain_chk();
    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    phase = "reset";
    repeat (2) @(negedge clk);
    chk("m_cycle",     32'(m_cycle),     32'(M_FETCH));
    chk("interrupt",   32'(interrupt),   32'd0);
    chk("halted",      32'(halted),      32'd0);
    chk("op_load",     32'(op_load),     32'd0);
    chk("prefix_load", 32'(prefix_load), 32'd0);
    chk("int_ack",     32'(int_ack),     32'd0);
`ifdef HALT_BUG_EN
    chk("pc_inc_inhibit", 32'(pc_inc_inhibit), 32'd0);
`endif
    n_reset = 1'b1;
    @(negedge clk);
    chk("op_load_no_tick", 32'(op_load), 32'd0);

    phase = "call_ime0";
    clr_cnt();
    op = 8'hCD;
    push(M_ROM_READ); push(M_ROM_READ); push(M_PUSH_PCH);
    push(M_PUSH_PCL); push(M_PC_WRITE); push(M_FETCH);
    repeat (6) tick();
    chk("op_load_count", 32'(n_opload), 32'd1);
    chk("int_ack_count", 32'(n_ack), 32'd0);
    drain_chk();

    phase = "jr_nz_taken_false";
    op = 8'h20; flag_z = 1'b1;
    push(M_ROM_READ); push(M_FETCH);
    repeat (2) tick();
    phase = "jr_nz_taken_true";
    flag_z = 1'b0;
    push(M_ROM_READ); push(M_PC_WRITE); push(M_FETCH);
    repeat (3) tick();
    drain_chk();

    phase = "ret_z_false";
    op = 8'hC8; flag_z = 1'b0;
    push(M_IDLE); push(M_FETCH);
    repeat (2) tick();

    phase = "cb_bit_hl_irq";
    clr_cnt();
    op = 8'hCB; op_prefix = 8'h46; ime = 1'b1; irq_pending = 1'b0;
    push(M_ROM_READ);
    tick();
    push(M_MEM_READ);
    tick();
    chk("prefix_load_count", 32'(n_pfx), 32'd1);
    irq_pending = 1'b1;
    push(M_BITALU_CALC);
    tick();
    push(M_IDLE, 1'b1); push(M_IDLE, 1'b1);
    repeat (2) tick();
    irq_pending = 1'b0;
    push(M_PUSH_PCH, 1'b1); push(M_PUSH_PCL, 1'b1); push(M_PC_WRITE, 1'b1);
    repeat (3) tick();
    chk("int_ack_before_pcw_tick", 32'(n_ack), 32'd0);
    push(M_FETCH, 1'b0);
    tick();
    chk("int_ack_count", 32'(n_ack), 32'd1);
    chk("prefix_load_total", 32'(n_pfx), 32'd1);
    ime = 1'b0;
    drain_chk();

    phase = "reset_mid_call";
    op = 8'hCD;
    push(M_ROM_READ); push(M_ROM_READ); push(M_PUSH_PCH); push(M_PUSH_PCL);
    repeat (4) tick();
    @(negedge clk);
    m_tick = 1'b1;
    #2 n_reset = 1'b0;
    #1;
    chk("m_cycle",     32'(m_cycle),     32'(M_FETCH));
    chk("op_load",     32'(op_load),     32'd0);
    chk("prefix_load", 32'(prefix_load), 32'd0);
    chk("int_ack",     32'(int_ack),     32'd0);
    chk("interrupt",   32'(interrupt),   32'd0);
    @(negedge clk);
    m_tick = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    clr_cnt();
    op = 8'h00;
    push(M_FETCH);
    tick();
    chk("nop_op_load", 32'(n_opload), 32'd1);
    drain_chk();

    phase = "halt_ime0";
    op = 8'h76; ime = 1'b0; irq_pending = 1'b0;
    push(M_IDLE, 1'b0, 1'b1);
    tick();
    repeat (9) begin
      push(M_IDLE, 1'b0, 1'b1);
      tick();
    end
    irq_pending = 1'b1;
    push(M_FETCH);
    tick();
`ifdef HALT_BUG_EN
    chk("pc_inc_inhibit_set", 32'(pc_inc_inhibit), 32'd1);
`endif
    irq_pending = 1'b0;
    op = 8'h00;
    push(M_FETCH);
    tick();
`ifdef HALT_BUG_EN
    chk("pc_inc_inhibit_clr", 32'(pc_inc_inhibit), 32'd0);
`endif
    drain_chk();

    phase = "halt_ime1";
    clr_cnt();
    op = 8'h76; ime = 1'b1;
    push(M_IDLE, 1'b0, 1'b1);
    tick();
    irq_pending = 1'b1;
    push(M_IDLE, 1'b1); push(M_IDLE, 1'b1); push(M_PUSH_PCH, 1'b1);
    push(M_PUSH_PCL, 1'b1); push(M_PC_WRITE, 1'b1); push(M_FETCH);
    repeat (6) tick();
    chk("int_ack_count", 32'(n_ack), 32'd1);
    ime = 1'b0; irq_pending = 1'b0;
    drain_chk();

    phase = "lock_d3";
    op = 8'hD3;
    push(M_IDLE);
    tick();
    for (int i = 0; i < 100; i++) begin
      irq_pending = 1'($urandom_range(0, 1));
      ime         = 1'($urandom_range(0, 1));
      push(M_IDLE);
      tick();
    end
    irq_pending = 1'b0; ime = 1'b0;
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    chk("lock_reset_m_cycle", 32'(m_cycle), 32'(M_FETCH));
    n_reset = 1'b1;

    phase = "ld_b_n_after_lock";
    op = 8'h06;
    push(M_ROM_READ); push(M_REG_WRITE); push(M_FETCH);
    repeat (3) tick();
    drain_chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
